// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 16x oversampled start qualification, LSB-first data, optional parity, stop.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote over the ticks ending at each sample point.
module uart_rx_ctrl #(
  parameter int OVS    = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              rx_in,
  input  logic [1:0]        parity_type,
  output logic [DATA_W-1:0] data,
  output logic              start_bit,
  output logic              parity_bit,
  output logic              stop_bit,
  output logic [1:0]        parity_type_q,
  output logic              recieved_flag,
  output logic              busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low sample on a baud tick
  // START  | counting to the middle of the start bit, then qualify it
  // DATA   | sampling DATA_W bits at the middle of each bit, LSB first
  // PARITY | sampling the parity bit (even/odd frames only)
  // STOP   | sampling the stop bit, publishing the frame fields
  // DONE   | one-cycle recieved_flag strobe, then back to IDLE

  localparam int TW = $clog2(OVS);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] T_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_s;
  logic [1:0]        frame_pt;
  logic              samp;
  logic              parity_en;
  logic              at_last;

`ifdef UART_RX_MAJORITY_EN
  // hist[0] holds rx_in from the previous tick, hist[1] from the one before.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b11;
    end else if (baud_tick) begin
      hist <= {hist[0], rx_in};
    end
  end

  assign samp = (hist[1] & hist[0]) | (hist[1] & rx_in) | (hist[0] & rx_in);
`else
  assign samp = rx_in;
`endif

  assign parity_en = frame_pt[0] ^ frame_pt[1];
  assign at_last   = baud_tick && (tick_cnt == T_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_s         <= 1'b0;
      frame_pt      <= 2'b00;
      data          <= '0;
      start_bit     <= 1'b0;
      parity_bit    <= 1'b0;
      stop_bit      <= 1'b1;
      parity_type_q <= 2'b00;
      recieved_flag <= 1'b0;
      busy          <= 1'b0;
    end else begin
      recieved_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (baud_tick && !rx_in) begin
            state    <= S_START;
            busy     <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            frame_pt <= parity_type;
          end
        end

        S_START: begin
          if (baud_tick) begin
            if (tick_cnt == T_MID) begin
              tick_cnt <= '0;
              if (samp) begin
                // Too short to be a start bit: drop it and leave the outputs alone.
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                start_bit <= 1'b0;
                state     <= S_DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (at_last) begin
            shreg[bit_cnt] <= samp;
            tick_cnt       <= '0;
            if (bit_cnt == B_LAST) begin
              bit_cnt <= '0;
              if (parity_en) begin
                state <= S_PARITY;
              end else begin
                par_s <= 1'b0;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (at_last) begin
            par_s    <= samp;
            tick_cnt <= '0;
            state    <= S_STOP;
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (at_last) begin
            // Fields are published together so errorch never sees a half-updated frame.
            data          <= shreg;
            parity_bit    <= par_s;
            stop_bit      <= samp;
            parity_type_q <= frame_pt;
            recieved_flag <= 1'b1;
            tick_cnt      <= '0;
            state         <= S_DONE;
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        S_DONE: begin
          tick_cnt <= '0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          tick_cnt <= '0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: vector table, hand-written corner sequences and a randomized line stream
// checked against a sample-point model of the frame format. Honours UART_RX_MAJORITY_EN.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx_in;
  logic [1:0] parity_type;
  logic [7:0] data;
  logic       start_bit;
  logic       parity_bit;
  logic       stop_bit;
  logic [1:0] parity_type_q;
  logic       recieved_flag;
  logic       busy;

  uart_rx_ctrl #(.OVS(16), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx_in         (rx_in),
    .parity_type   (parity_type),
    .data          (data),
    .start_bit     (start_bit),
    .parity_bit    (parity_bit),
    .stop_bit      (stop_bit),
    .parity_type_q (parity_type_q),
    .recieved_flag (recieved_flag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tick;
    logic [7:0] d;
    logic       sb;
    logic       pb;
    logic       st;
    logic [1:0] pt;
    logic       busy_f;
  } obs_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] pt;
    logic [1:0] pt_mid;
    logic       pbit;
    logic       stopv;
    int         stop_len;
    int         glitch;
    int         exp_flags;
    logic [7:0] exp_d;
    logic       exp_p;
    logic       exp_s;
    int         exp_lat;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   tick_no = 0;
  int   width_err = 0;
  int   busy_err = 0;
  logic prev_flag = 1'b0;
  obs_t mon_o;
  obs_t mon_q[$];
  obs_t exp_q[$];
  logic       line_q[$];
  logic [1:0] pt_q[$];

  // Every flag cycle is recorded with the index of the tick that produced it.
  always @(posedge clk) begin
    #1;
    if (recieved_flag) begin
      mon_o.tick   = tick_no;
      mon_o.d      = data;
      mon_o.sb     = start_bit;
      mon_o.pb     = parity_bit;
      mon_o.st     = stop_bit;
      mon_o.pt     = parity_type_q;
      mon_o.busy_f = busy;
      mon_q.push_back(mon_o);
      if (prev_flag) width_err++;
    end
    if (prev_flag && busy) busy_err++;
    prev_flag = recieved_flag;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_tick(input logic v, input logic [1:0] pt, input int gap);
    rx_in       = v;
    parity_type = pt;
    baud_tick   = 1'b1;
    tick_no++;
    @(negedge clk);
    baud_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic hold(input logic v, input logic [1:0] pt, input int n, input int gap);
    for (int i = 0; i < n; i++) do_tick(v, pt, gap);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] pt_mid,
                             input logic pbit, input logic stopv, input int stop_len, input int gap);
    hold(1'b0, pt, 1, gap);
    hold(1'b0, pt_mid, 15, gap);
    for (int k = 0; k < 8; k++) hold(d[k], pt_mid, 16, gap);
    if (pt == 2'b01 || pt == 2'b10) hold(pbit, pt_mid, 16, gap);
    hold(stopv, pt_mid, stop_len, gap);
  endtask

  function automatic logic samp(input int p);
    if (p >= line_q.size()) return 1'b1;
`ifdef UART_RX_MAJORITY_EN
    return (int'(line_q[p-2]) + int'(line_q[p-1]) + int'(line_q[p])) >= 2;
`else
    return line_q[p];
`endif
  endfunction

  initial begin
    vec_t       vt[7];
    int         t0;
    int         t1;
    int         base;
    int         n;
    int         m;
    logic [7:0] rb;
    logic       en;

    //        d      pt     pt_mid pbit  stop  slen glt flags exp_d  p     s     lat
    vt[0] = '{8'hA5, 2'b01, 2'b01, 1'b0, 1'b1, 16,  0,  1,    8'hA5, 1'b0, 1'b1, 168};
    vt[1] = '{8'h3C, 2'b11, 2'b10, 1'b0, 1'b1, 16,  0,  1,    8'h3C, 1'b0, 1'b1, 152};
    vt[2] = '{8'h00, 2'b01, 2'b01, 1'b0, 1'b1, 16,  3,  0,    8'h3C, 1'b0, 1'b1, 0};
    vt[3] = '{8'h55, 2'b10, 2'b10, 1'b1, 1'b0, 9,   0,  1,    8'h55, 1'b1, 1'b0, 168};
    vt[4] = '{8'h00, 2'b01, 2'b11, 1'b0, 1'b1, 16,  0,  1,    8'h00, 1'b0, 1'b1, 168};
    vt[5] = '{8'hFF, 2'b10, 2'b00, 1'b1, 1'b1, 12,  0,  1,    8'hFF, 1'b1, 1'b1, 168};
    vt[6] = '{8'h6E, 2'b00, 2'b01, 1'b1, 1'b1, 16,  0,  1,    8'h6E, 1'b0, 1'b1, 152};

    rst = 1'b1; baud_tick = 1'b0; rx_in = 1'b1; parity_type = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h0);
    check("rst_start", 32'(start_bit), 32'h0);
    check("rst_parity", 32'(parity_bit), 32'h0);
    check("rst_stop", 32'(stop_bit), 32'h1);
    check("rst_ptq", 32'(parity_type_q), 32'h0);
    check("rst_flag", 32'(recieved_flag), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      mon_q.delete();
      hold(1'b1, vt[r].pt, 4, 2);
      t0 = tick_no + 1;
      if (vt[r].glitch > 0) begin
        hold(1'b0, vt[r].pt, vt[r].glitch, 2);
        hold(1'b1, vt[r].pt, 8 - vt[r].glitch, 2);
        check($sformatf("v%0d_busy_start", r), 32'(busy), 32'h1);
        hold(1'b1, vt[r].pt, 1, 2);
        check($sformatf("v%0d_idle_at_tick8", r), 32'(busy), 32'h0);
        hold(1'b1, vt[r].pt, 6, 2);
      end else begin
        drive_frame(vt[r].d, vt[r].pt, vt[r].pt_mid, vt[r].pbit, vt[r].stopv, vt[r].stop_len, 2);
      end
      hold(1'b1, vt[r].pt_mid, 20, 2);
      check($sformatf("v%0d_flags", r), mon_q.size(), vt[r].exp_flags);
      if (mon_q.size() == 1) begin
        check($sformatf("v%0d_latency", r), mon_q[0].tick - t0, vt[r].exp_lat);
        check($sformatf("v%0d_flag_data", r), 32'(mon_q[0].d), 32'(vt[r].exp_d));
        check($sformatf("v%0d_flag_start", r), 32'(mon_q[0].sb), 32'h0);
        check($sformatf("v%0d_flag_ptq", r), 32'(mon_q[0].pt), 32'(vt[r].pt));
        check($sformatf("v%0d_flag_busy", r), 32'(mon_q[0].busy_f), 32'h1);
      end
      check($sformatf("v%0d_data", r), 32'(data), 32'(vt[r].exp_d));
      check($sformatf("v%0d_parity", r), 32'(parity_bit), 32'(vt[r].exp_p));
      check($sformatf("v%0d_stop", r), 32'(stop_bit), 32'(vt[r].exp_s));
      check($sformatf("v%0d_busy_end", r), 32'(busy), 32'h0);
    end

    // Reset in the middle of data bit 4, then a clean 0x81 frame without parity.
    mon_q.delete();
    hold(1'b1, 2'b00, 4, 2);
    rb = 8'h81;
    hold(1'b0, 2'b00, 16, 2);
    for (int k = 0; k < 4; k++) hold(rb[k], 2'b00, 16, 2);
    hold(rb[4], 2'b00, 8, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_data", 32'(data), 32'h0);
    check("abort_stop", 32'(stop_bit), 32'h1);
    check("abort_ptq", 32'(parity_type_q), 32'h0);
    hold(1'b1, 2'b00, 20, 2);
    check("abort_no_flag", mon_q.size(), 0);
    t0 = tick_no + 1;
    drive_frame(8'h81, 2'b00, 2'b00, 1'b0, 1'b1, 16, 2);
    hold(1'b1, 2'b00, 10, 2);
    check("after_abort_flags", mon_q.size(), 1);
    if (mon_q.size() == 1) begin
      check("after_abort_data", 32'(mon_q[0].d), 32'h81);
      check("after_abort_latency", mon_q[0].tick - t0, 152);
    end

    // Back-to-back frames at one tick per clk: the low tick landing on DONE is ignored.
    mon_q.delete();
    hold(1'b1, 2'b00, 4, 0);
    t0 = tick_no + 1;
    drive_frame(8'h5A, 2'b00, 2'b00, 1'b0, 1'b1, 9, 0);
    t1 = tick_no + 1;
    drive_frame(8'hC3, 2'b00, 2'b00, 1'b0, 1'b1, 16, 0);
    hold(1'b1, 2'b00, 10, 0);
    check("b2b_flags", mon_q.size(), 2);
    if (mon_q.size() == 2) begin
      check("b2b_first_data", 32'(mon_q[0].d), 32'h5A);
      check("b2b_first_latency", mon_q[0].tick - t0, 152);
      check("b2b_second_data", 32'(mon_q[1].d), 32'hC3);
      check("b2b_second_latency", mon_q[1].tick - t1, 153);
    end
    @(negedge clk);

    // One-tick low glitch exactly on the sample point of bit 3 of a 0xFF frame.
    mon_q.delete();
    hold(1'b1, 2'b00, 4, 2);
    hold(1'b0, 2'b00, 16, 2);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        hold(1'b1, 2'b00, 8, 2);
        hold(1'b0, 2'b00, 1, 2);
        hold(1'b1, 2'b00, 7, 2);
      end else begin
        hold(1'b1, 2'b00, 16, 2);
      end
    end
    hold(1'b1, 2'b00, 30, 2);
    check("glitch_flags", mon_q.size(), 1);
`ifdef UART_RX_MAJORITY_EN
    check("glitch_data", 32'(data), 32'hFF);
`else
    check("glitch_data", 32'(data), 32'hF7);
`endif

    // Random line stream; parity_type is random on every tick, only its value at the edge matters.
    line_q.delete();
    pt_q.delete();
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) begin line_q.push_back(1'b1); pt_q.push_back(2'($urandom_range(0, 3))); end
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin line_q.push_back(1'b0); pt_q.push_back(2'($urandom_range(0, 3))); end
        for (int i = 0; i < 10; i++) begin line_q.push_back(1'b1); pt_q.push_back(2'($urandom_range(0, 3))); end
      end else begin
        t0 = line_q.size();
        for (int i = 0; i < 16; i++) begin line_q.push_back(1'b0); pt_q.push_back(2'($urandom_range(0, 3))); end
        en = (pt_q[t0] == 2'b01) || (pt_q[t0] == 2'b10);
        rb = 8'($urandom_range(0, 255));
        for (int k = 0; k < 8; k++)
          for (int i = 0; i < 16; i++) begin line_q.push_back(rb[k]); pt_q.push_back(2'($urandom_range(0, 3))); end
        if (en) begin
          m = $urandom_range(0, 1);
          for (int i = 0; i < 16; i++) begin line_q.push_back(m[0]); pt_q.push_back(2'($urandom_range(0, 3))); end
        end
        m = ($urandom_range(0, 7) != 0) ? 1 : 0;
        n = $urandom_range(9, 16);
        for (int i = 0; i < n; i++) begin line_q.push_back(m[0]); pt_q.push_back(2'($urandom_range(0, 3))); end
      end
    end
    for (int i = 0; i < 40; i++) begin line_q.push_back(1'b1); pt_q.push_back(2'b00); end

    // Reference: walk the line tick by tick; a frame is read at its mid-bit sample points.
    exp_q.delete();
    begin
      int   i;
      int   p;
      obs_t e;
      i = 0;
      while (i < line_q.size()) begin
        if (line_q[i] == 1'b0) begin
          t0 = i;
          p  = t0 + 8;
          if (samp(p)) begin
            i = p + 1;
            continue;
          end
          e.d  = '0;
          e.sb = 1'b0;
          e.pt = pt_q[t0];
          for (int k = 0; k < 8; k++) begin
            p += 16;
            e.d[k] = samp(p);
          end
          e.pb = 1'b0;
          if (e.pt == 2'b01 || e.pt == 2'b10) begin
            p += 16;
            e.pb = samp(p);
          end
          p += 16;
          e.st     = samp(p);
          e.tick   = p;
          e.busy_f = 1'b1;
          exp_q.push_back(e);
          i = p + 1;
        end else begin
          i++;
        end
      end
    end

    mon_q.delete();
    base = tick_no;
    for (int i = 0; i < line_q.size(); i++) do_tick(line_q[i], pt_q[i], $urandom_range(1, 2));
    repeat (4) @(negedge clk);
    check("rand_frame_count", mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int j = 0; j < n; j++) begin
      check($sformatf("rand%0d_tick", j), mon_q[j].tick - base - 1, exp_q[j].tick);
      check($sformatf("rand%0d_data", j), 32'(mon_q[j].d), 32'(exp_q[j].d));
      check($sformatf("rand%0d_parity", j), 32'(mon_q[j].pb), 32'(exp_q[j].pb));
      check($sformatf("rand%0d_stop", j), 32'(mon_q[j].st), 32'(exp_q[j].st));
      check($sformatf("rand%0d_ptq", j), 32'(mon_q[j].pt), 32'(exp_q[j].pt));
      check($sformatf("rand%0d_start", j), 32'(mon_q[j].sb), 32'(exp_q[j].sb));
    end

    check("flag_single_cycle", width_err, 0);
    check("busy_low_after_flag", busy_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
